// File: rtl/cpu_inst_encoder_pkg.sv
// cpu_inst_encoder_pkg
//   Shared opcode and class-code constants for the RV32I instruction
//   encoder (the decoder uses the same values). It also holds the
//   instruction-format enumeration, the 33-bit {err, inst} word carried by
//   the skid buffer, and the immediate range helpers used when
//   CPU_ENC_RANGE_CHECK_EN is defined.
package cpu_inst_encoder_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARLOG_IMM = 7'b0010011;
  localparam logic [6:0] OP_ARLOG     = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  // Instruction class codes presented on in_class
  localparam logic [3:0] CLS_LUI       = 4'd0;
  localparam logic [3:0] CLS_AUIPC     = 4'd1;
  localparam logic [3:0] CLS_JAL       = 4'd2;
  localparam logic [3:0] CLS_JALR      = 4'd3;
  localparam logic [3:0] CLS_BRANCH    = 4'd4;
  localparam logic [3:0] CLS_LOAD      = 4'd5;
  localparam logic [3:0] CLS_STORE     = 4'd6;
  localparam logic [3:0] CLS_ARLOG_IMM = 4'd7;
  localparam logic [3:0] CLS_ARLOG     = 4'd8;
  localparam logic [3:0] CLS_MISC_MEM  = 4'd9;
  localparam logic [3:0] CLS_SYSTEM    = 4'd10;

  // addi x0, x0, 0 -- substituted for unknown classes
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // funct3 values that select the shift-immediate layout within ARLOG_IMM
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  // Word stored in the skid buffer; err sits in the top bit.
  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_word_t;

  // Immediate fits a 12-bit signed field (I/S formats).
  function automatic logic fits_s12(input logic [31:0] imm);
    return imm[31:11] == {21{imm[11]}};
  endfunction

  // Immediate fits a 13-bit signed field (B format, before the even check).
  function automatic logic fits_s13(input logic [31:0] imm);
    return imm[31:12] == {20{imm[12]}};
  endfunction

  // Immediate fits a 21-bit signed field (J format, before the even check).
  function automatic logic fits_s21(input logic [31:0] imm);
    return imm[31:20] == {12{imm[20]}};
  endfunction

endpackage

// File: rtl/cpu_inst_encoder_if.sv
// cpu_inst_encoder_if
//   Bundles the encoder's input field handshake and output word handshake.
//   master : the producer/consumer side (debug injector, self-test, bench)
//   slave  : the encoder itself
//   Input side : in_valid, in_ready, in_class, in_funct, in_rd, in_rs1,
//                in_rs2, in_imm
//   Output side: out_valid, out_ready, out_inst, out_err
interface cpu_inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [9:0]  in_funct;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, in_class, in_funct, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_class, in_funct, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/cpu_inst_encoder_skid.sv
// cpu_inst_encoder_skid
//   Two-entry valid/ready skid buffer for 33-bit {err, inst} words.
//   The main register M drives the outputs and the skid register S absorbs
//   the one word that arrives while M is stalled. in_ready comes straight
//   from a flop (!S.valid), so it has no combinational path from out_ready.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid/in_ready    upstream handshake, in_data word
//     out_valid/out_ready  downstream handshake, out_data word (from M)
module cpu_inst_encoder_skid
  import cpu_inst_encoder_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  enc_word_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output enc_word_t out_data
);

  logic      m_valid_q, m_valid_d;
  enc_word_t m_data_q, m_data_d;
  logic      s_valid_q, s_valid_d;
  enc_word_t s_data_q, s_data_d;

  logic push;
  logic pop;

  assign push = in_valid && !s_valid_q;
  assign pop  = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (pop && s_valid_q) begin
      // Drain the skid entry into M. push is 0 here because in_ready is low.
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
    end else begin
      if (pop) begin
        m_valid_d = 1'b0;
      end
      if (push) begin
        if (!m_valid_q || pop) begin
          // M is empty or emptying this cycle: refill it directly, so there
          // is no bubble.
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end else begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

endmodule

// File: rtl/cpu_inst_encoder.sv
// cpu_inst_encoder
//   Assembles RV32I instruction words from decoded fields (class, funct,
//   rd, rs1, rs2, imm); this is the inverse of the instruction-register
//   decode. The format mux is combinational, and the {err, inst} result is
//   queued in a two-entry skid buffer.
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     bus   cpu_inst_encoder_if.slave: in_* field handshake in,
//           out_valid/out_ready/out_inst/out_err word out
//   Build option:
//     CPU_ENC_RANGE_CHECK_EN  when defined, out_err also flags immediates
//                             that do not fit their format. The encoded bits
//                             are still the truncated value.
module cpu_inst_encoder
  import cpu_inst_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cpu_inst_encoder_if.slave bus
);

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [31:0] enc_inst;
  logic        range_err;
  enc_word_t   enc_word;
  enc_word_t   out_word;

  logic [6:0]  funct7;
  logic [2:0]  funct3;

  assign funct7 = bus.in_funct[9:3];
  assign funct3 = bus.in_funct[2:0];

  // Class -> format and opcode.
  always_comb begin
    fmt    = FMT_BAD;
    opcode = OP_ARLOG_IMM;
    case (bus.in_class)
      CLS_LUI:       begin fmt = FMT_U; opcode = OP_LUI;      end
      CLS_AUIPC:     begin fmt = FMT_U; opcode = OP_AUIPC;    end
      CLS_JAL:       begin fmt = FMT_J; opcode = OP_JAL;      end
      CLS_JALR:      begin fmt = FMT_I; opcode = OP_JALR;     end
      CLS_BRANCH:    begin fmt = FMT_B; opcode = OP_BRANCH;   end
      CLS_LOAD:      begin fmt = FMT_I; opcode = OP_LOAD;     end
      CLS_STORE:     begin fmt = FMT_S; opcode = OP_STORE;    end
      CLS_ARLOG_IMM: begin
        // Shift-immediates carry funct7 in the top bits and a 5-bit shamt.
        if (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI) begin
          fmt = FMT_SH;
        end else begin
          fmt = FMT_I;
        end
        opcode = OP_ARLOG_IMM;
      end
      CLS_ARLOG:     begin fmt = FMT_R; opcode = OP_ARLOG;    end
      CLS_MISC_MEM:  begin fmt = FMT_I; opcode = OP_MISC_MEM; end
      CLS_SYSTEM:    begin fmt = FMT_I; opcode = OP_SYSTEM;   end
      default:       begin fmt = FMT_BAD; opcode = OP_ARLOG_IMM; end
    endcase
  end

  // Format -> bit layout. Fields a format does not use are dropped.
  always_comb begin
    enc_inst = INST_NOP;
    case (fmt)
      FMT_R:  enc_inst = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, opcode};
      FMT_I:  enc_inst = {bus.in_imm[11:0], bus.in_rs1, funct3, bus.in_rd, opcode};
      FMT_SH: enc_inst = {funct7, bus.in_imm[4:0], bus.in_rs1, funct3, bus.in_rd, opcode};
      FMT_S:  enc_inst = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, funct3,
                          bus.in_imm[4:0], opcode};
      FMT_B:  enc_inst = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                          funct3, bus.in_imm[4:1], bus.in_imm[11], opcode};
      FMT_U:  enc_inst = {bus.in_imm[31:12], bus.in_rd, opcode};
      FMT_J:  enc_inst = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                          bus.in_imm[19:12], bus.in_rd, opcode};
      default: enc_inst = INST_NOP;
    endcase
  end

`ifdef CPU_ENC_RANGE_CHECK_EN
  // Flag immediates that the chosen format cannot represent exactly.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = !fits_s12(bus.in_imm);
      FMT_SH:       range_err = |bus.in_imm[31:5];
      FMT_B:        range_err = !fits_s13(bus.in_imm) || bus.in_imm[0];
      FMT_J:        range_err = !fits_s21(bus.in_imm) || bus.in_imm[0];
      FMT_U:        range_err = |bus.in_imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign enc_word.inst = enc_inst;
  assign enc_word.err  = (fmt == FMT_BAD) || range_err;

  cpu_inst_encoder_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (enc_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_word)
  );

  assign bus.out_inst = out_word.inst;
  assign bus.out_err  = out_word.err;

endmodule

// File: tb/tb_cpu_inst_encoder.sv
// tb_cpu_inst_encoder
//   Directed vectors with known encodings, skid-buffer stall/reset
//   scenarios, then randomized traffic checked against a queue-based
//   reference model that builds each word arithmetically from the field rules.
module tb_cpu_inst_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cpu_inst_encoder_if bus ();

  cpu_inst_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  logic [32:0] exp_q[$];
  logic [32:0] emitted[$];
  logic        last_push;

  bit [31:0] op_tab [0:10] = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03,
                               32'h23, 32'h13, 32'h33, 32'h0F, 32'h73};

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder: returns {err, inst}.
  function automatic logic [32:0] model_enc(input logic [3:0] cls, input logic [9:0] funct,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
    bit [31:0] op, f3, f7, vrd, vrs1, vrs2, im, w;
    int        s;
    bit        err;
    if (cls > 4'd10) return {1'b1, 32'h0000_0013};
    op = op_tab[cls];
    f3 = 32'(funct) & 7;
    f7 = 32'(funct) >> 3;
    vrd = 32'(rd); vrs1 = 32'(rs1); vrs2 = 32'(rs2);
    im = imm;
    s = $signed(imm);
    err = 1'b0;
    case (cls)
      4'd0, 4'd1: begin
        w = op | (vrd << 7) | (im & 32'hFFFF_F000);
        err = (im & 32'hFFF) != 0;
      end
      4'd2: begin
        w = op | (vrd << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 1) << 20)
              | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 1) << 31);
        err = (s < -(1 << 20)) || (s > (1 << 20) - 1) || im[0];
      end
      4'd4: begin
        w = op | (((im >> 11) & 1) << 7) | (((im >> 1) & 15) << 8) | (f3 << 12)
              | (vrs1 << 15) | (vrs2 << 20) | (((im >> 5) & 63) << 25) | (((im >> 12) & 1) << 31);
        err = (s < -4096) || (s > 4095) || im[0];
      end
      4'd6: begin
        w = op | ((im & 31) << 7) | (f3 << 12) | (vrs1 << 15) | (vrs2 << 20)
              | (((im >> 5) & 127) << 25);
        err = (s < -2048) || (s > 2047);
      end
      4'd8: begin
        w = op | (vrd << 7) | (f3 << 12) | (vrs1 << 15) | (vrs2 << 20) | (f7 << 25);
      end
      default: begin
        if (cls == 4'd7 && (f3 == 1 || f3 == 5)) begin
          w = op | (vrd << 7) | (f3 << 12) | (vrs1 << 15) | ((im & 31) << 20) | (f7 << 25);
          err = im > 31;
        end else begin
          w = op | (vrd << 7) | (f3 << 12) | (vrs1 << 15) | ((im & 32'hFFF) << 20);
          err = (s < -2048) || (s > 2047);
        end
      end
    endcase
`ifdef CPU_ENC_RANGE_CHECK_EN
    return {err, w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic drive(input logic [3:0] cls, input logic [9:0] funct, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_class = cls;
    bus.in_funct = funct;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  // One clock: check DUT against the model at the falling edge, then advance
  // the model at the rising edge. Returns 1 ns after the rising edge.
  task automatic cycle();
    logic push, pop;
    @(negedge clk);
    chk("out_valid", {32'b0, bus.out_valid}, {32'b0, exp_q.size() > 0});
    chk("in_ready", {32'b0, bus.in_ready}, {32'b0, exp_q.size() < 2});
    if (exp_q.size() > 0) chk("out_word", {bus.out_err, bus.out_inst}, exp_q[0]);
    push = bus.in_valid && (exp_q.size() < 2);
    pop  = (exp_q.size() > 0) && bus.out_ready;
    if (pop && !rst) emitted.push_back({bus.out_err, bus.out_inst});
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      last_push = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(model_enc(bus.in_class, bus.in_funct, bus.in_rd,
                                          bus.in_rs1, bus.in_rs2, bus.in_imm));
      last_push = push;
    end
    #1;
  endtask

  // Single word through an idle buffer, checked against a known encoding.
  task automatic send_check(input string tag, input logic [3:0] cls, input logic [9:0] funct,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic [31:0] exp_inst,
                            input logic exp_err);
    drive(cls, funct, rd, rs1, rs2, imm);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk(tag, {bus.out_err, bus.out_inst}, {exp_err, exp_inst});
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timed out");
  end

  initial begin
    int ncyc;
    logic [31:0] r;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(4'd0, 10'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    last_push = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {32'b0, bus.out_valid}, 33'd0);
    chk("rst_in_ready", {32'b0, bus.in_ready}, 33'd1);
    chk("rst_word", {bus.out_err, bus.out_inst}, 33'd0);

    // Directed encodings
    send_check("addi_neg1", 4'd7, 10'h000, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    send_check("sub", 4'd8, {7'b0100000, 3'b000}, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    send_check("srai", 4'd7, {7'b0100000, 3'b101}, 5'd5, 5'd5, 5'd0, 32'd3, 32'h4032_D293, 1'b0);
    send_check("jal", 4'd2, 10'h3FF, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send_check("beq_m4", 4'd4, 10'h000, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    send_check("bad_cls", 4'd12, 10'h3FF, 5'd7, 5'd7, 5'd7, 32'h1234_5678, 32'h0000_0013, 1'b1);
    send_check("lui", 4'd0, 10'h3FF, 5'd10, 5'd3, 5'd4, 32'hABCDE000, 32'hABCD_E537, 1'b0);
`ifdef CPU_ENC_RANGE_CHECK_EN
    send_check("rc_addi_800", 4'd7, 10'h000, 5'd0, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0013, 1'b1);
    send_check("rc_b_6", 4'd4, 10'h000, 5'd0, 5'd0, 5'd0, 32'd6, 32'h0000_0363, 1'b0);
    send_check("rc_b_5", 4'd4, 10'h000, 5'd0, 5'd0, 5'd0, 32'd5, 32'h0000_0263, 1'b1);
`endif

    // Three back-to-back words into a stalled output
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(4'd7, 10'h000, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
    cycle();
    drive(4'd8, {7'b0100000, 3'b000}, 5'd3, 5'd1, 5'd2, 32'd0);
    cycle();
    chk("b2b_in_ready_low", {32'b0, bus.in_ready}, 33'd0);
    drive(4'd7, {7'b0100000, 3'b101}, 5'd5, 5'd5, 5'd0, 32'd3);
    cycle();
    chk("b2b_hold", {bus.out_err, bus.out_inst}, {1'b0, 32'hFFF1_0093});
    chk("b2b_third_refused", {32'b0, last_push}, 33'd0);
    bus.out_ready = 1'b1;
    emitted.delete();
    ncyc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      ncyc++;
      if (last_push) bus.in_valid = 1'b0;
      if (!bus.in_valid && exp_q.size() == 0) break;
    end
    chk("b2b_cycles", 33'(ncyc), 33'd3);
    chk("b2b_count", 33'(emitted.size()), 33'd3);
    if (emitted.size() == 3) begin
      chk("b2b_w0", emitted[0], {1'b0, 32'hFFF1_0093});
      chk("b2b_w1", emitted[1], {1'b0, 32'h4020_81B3});
      chk("b2b_w2", emitted[2], {1'b0, 32'h4032_D293});
    end

    // Reset while full, with a handshake offered during reset
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(4'd5, 10'h002, 5'd4, 5'd6, 5'd0, 32'd16);
    cycle();
    drive(4'd6, 10'h002, 5'd0, 5'd6, 5'd9, 32'hFFFF_FFF0);
    cycle();
    chk("full_in_ready", {32'b0, bus.in_ready}, 33'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_out_valid", {32'b0, bus.out_valid}, 33'd0);
    chk("mid_rst_in_ready", {32'b0, bus.in_ready}, 33'd1);
    chk("mid_rst_word", {bus.out_err, bus.out_inst}, 33'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = $urandom;
        1: r = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: r = 32'($urandom_range(0, 63));
        default: r = $urandom & 32'hFFFF_F000;
      endcase
      drive(4'($urandom_range(0, 15)), 10'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), r);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
